// File: rtl/algorithm_control.sv
// MMIO-driven run controller: launches a kernel, tracks the run, and reports
// completion codes, run count and sticky errors as 64-bit words (bit 63 = LSB).
module algorithm_control #(
    parameter logic [31:0] RUN_TIMEOUT = 32'd0
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic [0:63] algorithm_requests,
    input  logic        report_algorithm_status_ack,
    input  logic        report_errors_ack,
    input  logic        kernel_done,
    input  logic [0:61] kernel_error,
    output logic        kernel_start,
    output logic [0:63] algorithm_status,
    output logic [0:63] algorithm_status_done,
    output logic [0:63] algorithm_running,
    output logic [0:63] report_errors
);

    typedef enum logic [7:0] {
        IDLE    = 8'h00,
        START   = 8'h01,
        RUNNING = 8'h02,
        FINISH  = 8'h03,
        ABORT   = 8'h04
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        kernel_start_q, kernel_start_d;
    logic [0:63] status_q, status_d;
    logic [0:63] done_q, done_d;
    logic [0:63] running_q, running_d;
    logic [0:63] errors_q, errors_d;

    logic        req_start, req_abort, any_kerr, timeout_hit, timeout_set, busy_err;
    logic [0:63] err_set;
    logic        unused_req;

    assign req_start  = algorithm_requests[63];
    assign req_abort  = algorithm_requests[62];
    assign unused_req = ^algorithm_requests[0:61];
    assign any_kerr   = |kernel_error;
    assign timeout_hit = (RUN_TIMEOUT != 32'd0) && (cyc_cnt_q == RUN_TIMEOUT - 32'd1);

    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        case (state_q)
            IDLE:    if (req_start && !req_abort) state_d = START;
            START:   state_d = RUNNING;
            RUNNING: begin
                if (req_abort || any_kerr) begin
                    state_d = ABORT;
                end else if (timeout_hit) begin
                    state_d     = ABORT;
                    timeout_set = 1'b1;
                end else if (kernel_done) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_err = req_start && (state_q != IDLE);

        cyc_cnt_d = cyc_cnt_q;
        if (state_q == START) begin
            cyc_cnt_d = 32'd0;
        end else if (state_q == RUNNING && cyc_cnt_q != 32'hFFFF_FFFF) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end

        run_cnt_d = (state_q == FINISH) ? run_cnt_q + 32'd1 : run_cnt_q;

        // Done word: ack clears, but a same-cycle FINISH/ABORT write wins.
        done_d = report_algorithm_status_ack ? 64'h0 : done_q;
        if (state_q == FINISH) done_d = 64'h1;
        if (state_q == ABORT)  done_d = 64'h2;

        err_set         = 64'h0;
        err_set[0:61]   = kernel_error;
        err_set[62]     = timeout_set;
        err_set[63]     = busy_err;
        errors_d        = (report_errors_ack ? 64'h0 : errors_q) | err_set;

        kernel_start_d  = (state_d == START);
        // Running is raised with the launch pulse and dropped one cycle after RUNNING ends.
        running_d       = 64'h0;
        running_d[63]   = (state_d == START) || (state_q == START) || (state_q == RUNNING);
        status_d        = {run_cnt_d, 24'h0, state_d};
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cyc_cnt_q      <= 32'd0;
            run_cnt_q      <= 32'd0;
            kernel_start_q <= 1'b0;
            status_q       <= 64'h0;
            done_q         <= 64'h0;
            running_q      <= 64'h0;
            errors_q       <= 64'h0;
        end else begin
            state_q        <= state_d;
            cyc_cnt_q      <= cyc_cnt_d;
            run_cnt_q      <= run_cnt_d;
            kernel_start_q <= kernel_start_d;
            status_q       <= status_d;
            done_q         <= done_d;
            running_q      <= running_d;
            errors_q       <= errors_d;
        end
    end

    assign kernel_start          = kernel_start_q;
    assign algorithm_status      = status_q;
    assign algorithm_status_done = done_q;
    assign algorithm_running     = running_q;
    assign report_errors         = errors_q;

endmodule

// File: tb/tb_algorithm_control.sv
// Directed bench for algorithm_control: default instance plus a RUN_TIMEOUT=5 instance.
module tb_algorithm_control;
    logic        clock = 1'b0;
    logic        rstn;
    logic [0:63] req, req2;
    logic        st_ack, er_ack, kd, kd2;
    logic [0:61] ke, ke2;
    logic        kstart, kstart2;
    logic [0:63] status, done, running, errors;
    logic [0:63] status2, done2, running2, errors2;
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    algorithm_control dut (
        .clock(clock), .rstn(rstn), .algorithm_requests(req),
        .report_algorithm_status_ack(st_ack), .report_errors_ack(er_ack),
        .kernel_done(kd), .kernel_error(ke), .kernel_start(kstart),
        .algorithm_status(status), .algorithm_status_done(done),
        .algorithm_running(running), .report_errors(errors)
    );

    algorithm_control #(.RUN_TIMEOUT(32'd5)) dut_to (
        .clock(clock), .rstn(rstn), .algorithm_requests(req2),
        .report_algorithm_status_ack(st_ack), .report_errors_ack(er_ack),
        .kernel_done(kd2), .kernel_error(ke2), .kernel_start(kstart2),
        .algorithm_status(status2), .algorithm_status_done(done2),
        .algorithm_running(running2), .report_errors(errors2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rstn = 1'b0; req = '0; req2 = '0; st_ack = 0; er_ack = 0;
        kd = 0; kd2 = 0; ke = '0; ke2 = '0;
        repeat (2) tick();
        chk("rst_kstart", {63'h0, kstart}, 64'h0);
        chk("rst_status", status, 64'h0);
        chk("rst_running", running, 64'h0);
        chk("rst_errors", errors, 64'h0);
        rstn = 1'b1;
        tick();

        // Normal run: start at N, kernel_done at N+10
        req = 64'h1; tick(); req = '0;
        chk("n1_kstart", {63'h0, kstart}, 64'h1);
        chk("n1_running", running, 64'h1);
        chk("n1_status", status, 64'h1);
        tick();
        chk("n2_kstart", {63'h0, kstart}, 64'h0);
        chk("n2_status", status, 64'h2);
        repeat (8) tick();
        kd = 1; tick(); kd = 0;
        chk("n11_running", running, 64'h1);
        chk("n11_status", status, 64'h3);
        chk("n11_done", done, 64'h0);
        tick();
        chk("n12_done", done, 64'h1);
        chk("n12_status", status, 64'h0000_0001_0000_0000);
        chk("n12_running", running, 64'h0);

        // Timeout instance: ABORT after 5 RUNNING cycles
        req2 = 64'h1; tick(); req2 = '0;
        repeat (6) tick();
        chk("to_state", status2, 64'h4);
        chk("to_errors", errors2, 64'h2);
        chk("to_running", running2, 64'h1);
        tick();
        chk("to_done", done2, 64'h2);
        chk("to_status", status2, 64'h0);
        chk("to_running_off", running2, 64'h0);

        // Start while busy
        req = 64'h1; tick(); req = '0; tick();
        req = 64'h1; tick(); req = '0;
        chk("busy_err", errors, 64'h1);
        chk("busy_state", status, 64'h0000_0001_0000_0002);
        kd = 1; tick(); kd = 0; tick();
        chk("busy_done", done, 64'h1);
        chk("busy_cnt", status, 64'h0000_0002_0000_0000);
        er_ack = 1; tick(); er_ack = 0;
        chk("err_ack", errors, 64'h0);

        // Abort command during RUNNING
        req = 64'h1; tick(); req = '0; tick();
        req = 64'h2; tick(); req = '0;
        chk("ab_state", status, 64'h0000_0002_0000_0004);
        tick();
        chk("ab_done", done, 64'h2);
        chk("ab_cnt", status, 64'h0000_0002_0000_0000);

        // Start+abort in IDLE, lone abort in IDLE: ignored, no error
        req = 64'h3; tick(); req = '0;
        chk("sa_kstart", {63'h0, kstart}, 64'h0);
        chk("sa_running", running, 64'h0);
        req = 64'h2; tick(); req = '0;
        chk("ia_errors", errors, 64'h0);
        chk("ia_done", done, 64'h2);

        // Kernel error beats simultaneous kernel_done
        req = 64'h1; tick(); req = '0; tick();
        ke[0] = 1'b1; kd = 1; tick(); ke = '0; kd = 0;
        chk("ke_errors", errors, 64'h8000_0000_0000_0000);
        chk("ke_state", status, 64'h0000_0002_0000_0004);
        tick();
        chk("ke_done", done, 64'h2);
        chk("ke_cnt", status, 64'h0000_0002_0000_0000);
        er_ack = 1; tick(); er_ack = 0;
        chk("ke_ack", errors, 64'h0);

        // Status ack coincident with FINISH, then lone ack
        req = 64'h1; tick(); req = '0; tick();
        kd = 1; tick(); kd = 0;
        st_ack = 1; tick(); st_ack = 0;
        chk("ack_fin_done", done, 64'h1);
        chk("ack_fin_cnt", status, 64'h0000_0003_0000_0000);
        st_ack = 1; tick(); st_ack = 0;
        chk("ack_lone", done, 64'h0);

        // Reset mid-run
        req = 64'h1; tick(); req = '0; tick(); tick();
        #2 rstn = 1'b0;
        #1;
        chk("mr_running", running, 64'h0);
        chk("mr_status", status, 64'h0);
        chk("mr_done", done, 64'h0);
        chk("mr_errors", errors, 64'h0);
        tick();
        rstn = 1'b1;
        tick();
        chk("mr_idle", status, 64'h0);
        chk("mr_kstart", {63'h0, kstart}, 64'h0);
        req = 64'h1; tick(); req = '0;
        chk("mr_restart", {63'h0, kstart}, 64'h1);
        tick();
        kd = 1; tick(); kd = 0; tick();
        chk("mr_done2", done, 64'h1);
        chk("mr_cnt", status, 64'h0000_0001_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
